// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the HH/STDP neuron pair and its spike event logger.
//   DEFAULT_TS_WIDTH : default width of the free-running event timestamp
//   FLAG_*           : two-bit {flag_a, flag_b} tags carried by each event entry
//   entry_width()    : width of one logged entry for a given timestamp width
// -----------------------------------------------------------------------------
package neuron_pkg;

  localparam int DEFAULT_TS_WIDTH = 14;

  // An all-zero flag pair only ever accompanies the all-ones timestamp and
  // marks a timestamp rollover rather than a spike.
  localparam logic [1:0] FLAG_WRAP = 2'b00;
  localparam logic [1:0] FLAG_A    = 2'b10;
  localparam logic [1:0] FLAG_B    = 2'b01;
  localparam logic [1:0] FLAG_AB   = 2'b11;

  function automatic int entry_width(input int ts_width);
    return ts_width + 2;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// head_data whenever the FIFO is non-empty; a pop simply advances past it.
//   clk, reset_n : clock and asynchronous active-low reset
//   push         : write request (accepted when not full, or full with a pop)
//   push_data    : entry to write
//   pop          : read request (ignored when empty)
//   full, empty  : occupancy status
//   count        : current occupancy, 0..DEPTH
//   head_data    : oldest entry, zero when empty
// Storage is not reset; only pointers and occupancy are.
// -----------------------------------------------------------------------------
module sync_fifo_fwft
  import neuron_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [WIDTH-1:0]  head_data
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == '0);
  assign count = r_count;

  // A full FIFO still accepts a write when the head leaves in the same cycle;
  // there is no empty-to-output bypass, so a write always lands in storage.
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  assign head_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// -----------------------------------------------------------------------------
// spike_event_logger
// Stamps rising edges of the presynaptic (a) and postsynaptic (b) spike lines
// with a free-running timestamp and queues them for readout.
//   clk, reset_n : clock and asynchronous active-low reset
//   en           : logging enable; gates timestamp advance and event pushes
//   spike_a/b    : registered spike levels from the two neurons
//   rd_ready     : consumer ready; with rd_valid forms the pop handshake
//   rd_valid     : head entry valid
//   rd_data      : {flag_a, flag_b, timestamp}, zero when not valid
//   count        : FIFO occupancy, 0..DEPTH
//   overflow     : sticky flag, set when an event was dropped on a full FIFO
//   clear_ovf    : synchronous clear of overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module spike_event_logger
  import neuron_pkg::*;
#(
  parameter int TS_WIDTH = DEFAULT_TS_WIDTH,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 spike_a,
  input  logic                 spike_b,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [TS_WIDTH+1:0]  rd_data,
  output logic [ADDR_W:0]      count,
  output logic                 overflow,
  input  logic                 clear_ovf
);

  localparam int ENTRY_W = entry_width(TS_WIDTH);

  logic                r_spike_a_q;
  logic                r_spike_b_q;
  logic [TS_WIDTH-1:0] r_ts;
  logic                r_overflow;

  logic                w_ev_a;
  logic                w_ev_b;
  logic                w_any_ev;
  logic                w_ts_max;
  logic                w_push_req;
  logic [ENTRY_W-1:0]  w_push_data;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;

  // The delayed copies track the lines even while logging is disabled, so a
  // level that is already high when en rises is not mistaken for a new spike.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spike_a_q <= 1'b0;
      r_spike_b_q <= 1'b0;
    end else begin
      r_spike_a_q <= spike_a;
      r_spike_b_q <= spike_b;
    end
  end

  assign w_ev_a   = spike_a & ~r_spike_a_q;
  assign w_ev_b   = spike_b & ~r_spike_b_q;
  assign w_any_ev = w_ev_a | w_ev_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts <= '0;
    end else if (en) begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  assign w_ts_max = &r_ts;

  // Entries carry the pre-increment timestamp. In the rollover cycle a spike
  // entry takes the place of the wrap marker: its all-ones timestamp already
  // tells the consumer the counter wrapped.
  assign w_push_req  = en & (w_any_ev | w_ts_max);
  assign w_push_data = w_any_ev ? {w_ev_a, w_ev_b, r_ts} : {FLAG_WRAP, r_ts};

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push_req),
    .push_data (w_push_data),
    .pop       (rd_ready),
    .full      (w_full),
    .empty     (w_empty),
    .count     (count),
    .head_data (rd_data)
  );

  assign rd_valid = ~w_empty;

  // A full FIFO is never empty, so rd_ready alone decides whether the head
  // leaves and frees a slot for the incoming entry.
  assign w_drop = w_push_req & w_full & ~rd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_spike_event_logger.sv
// -----------------------------------------------------------------------------
// tb_spike_event_logger
// Directed bench for the spike event logger: a default-width instance plus a
// 4-bit timestamp instance for exercising the rollover marker.
// -----------------------------------------------------------------------------
module tb_spike_event_logger;

  logic        clk;
  logic        reset_n;
  logic        en, spikeA, spikeB, rdReady, clearOvf;
  logic        rdValid, overflowFlag;
  logic [15:0] rdData;
  logic [3:0]  count;

  logic        en4, spikeA4, spikeB4, rdReady4, clearOvf4;
  logic        rdValid4, overflow4;
  logic [5:0]  rdData4;
  logic [3:0]  count4;

  int nVectors;
  int nMiscompares;

  spike_event_logger #(.TS_WIDTH(14), .DEPTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .spike_a   (spikeA),
    .spike_b   (spikeB),
    .rd_ready  (rdReady),
    .rd_valid  (rdValid),
    .rd_data   (rdData),
    .count     (count),
    .overflow  (overflowFlag),
    .clear_ovf (clearOvf)
  );

  spike_event_logger #(.TS_WIDTH(4), .DEPTH(8)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en4),
    .spike_a   (spikeA4),
    .spike_b   (spikeB4),
    .rd_ready  (rdReady4),
    .rd_valid  (rdValid4),
    .rd_data   (rdData4),
    .count     (count4),
    .overflow  (overflow4),
    .clear_ovf (clearOvf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    en        = 1'b0; spikeA  = 1'b0; spikeB  = 1'b0; rdReady  = 1'b0; clearOvf  = 1'b0;
    en4       = 1'b0; spikeA4 = 1'b0; spikeB4 = 1'b0; rdReady4 = 1'b0; clearOvf4 = 1'b0;
    applyStimulus(2);
    reset_n = 1'b1;
    applyStimulus(1);
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;

    // ---- reset state ----
    doReset();
    checkOutput("reset_valid", rdValid, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_data", rdData, 0);
    checkOutput("reset_ovf", overflowFlag, 0);

    // ---- 1: single spike_a at ts=5, held high 3 cycles ----
    en = 1'b1;
    applyStimulus(5);
    spikeA = 1'b1;
    checkOutput("t1_valid_before", rdValid, 0);
    applyStimulus(1);
    checkOutput("t1_valid_after", rdValid, 1);
    checkOutput("t1_data", rdData, 16'h8005);
    checkOutput("t1_count", count, 1);
    applyStimulus(2);
    checkOutput("t1_count_held", count, 1);
    spikeA = 1'b0;

    // ---- 2: simultaneous spikes at ts=20, then pop ----
    doReset();
    en = 1'b1;
    applyStimulus(20);
    spikeA = 1'b1; spikeB = 1'b1;
    applyStimulus(1);
    checkOutput("t2_data", rdData, 16'hC014);
    checkOutput("t2_count", count, 1);
    rdReady = 1'b1;
    applyStimulus(1);
    checkOutput("t2_pop_count", count, 0);
    checkOutput("t2_pop_valid", rdValid, 0);
    checkOutput("t2_pop_data", rdData, 0);
    rdReady = 1'b0; spikeA = 1'b0; spikeB = 1'b0;

    // ---- 3: nine spike_b pulses at ts=2..18 overflow an 8-deep FIFO ----
    doReset();
    en = 1'b1;
    applyStimulus(2);
    for (int i = 0; i < 9; i++) begin
      spikeB = 1'b1;
      applyStimulus(1);
      spikeB = 1'b0;
      applyStimulus(1);
    end
    checkOutput("t3_count_full", count, 8);
    checkOutput("t3_ovf_set", overflowFlag, 1);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t3_drain", rdData, 32'h4000 + 2 * (i + 1));
      rdReady = 1'b1;
      applyStimulus(1);
    end
    rdReady = 1'b0;
    checkOutput("t3_drained_count", count, 0);
    checkOutput("t3_ovf_sticky", overflowFlag, 1);
    clearOvf = 1'b1;
    applyStimulus(1);
    clearOvf = 1'b0;
    checkOutput("t3_ovf_cleared", overflowFlag, 0);

    // ---- 4: full FIFO, pop and push in the same cycle at ts=30 ----
    doReset();
    en = 1'b1;
    applyStimulus(2);
    for (int i = 0; i < 8; i++) begin
      spikeB = 1'b1;
      applyStimulus(1);
      spikeB = 1'b0;
      applyStimulus(1);
    end
    checkOutput("t4_count_full", count, 8);
    applyStimulus(12);
    spikeA = 1'b1; rdReady = 1'b1;
    applyStimulus(1);
    rdReady = 1'b0; spikeA = 1'b0;
    checkOutput("t4_count_stays", count, 8);
    checkOutput("t4_ovf_clear", overflowFlag, 0);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checkOutput("t4_drain", rdData, 32'h4000 + 2 * (i + 2));
      rdReady = 1'b1;
      applyStimulus(1);
    end
    checkOutput("t4_last_entry", rdData, 16'h801E);
    applyStimulus(1);
    rdReady = 1'b0;
    checkOutput("t4_empty", count, 0);

    // ---- 5: 4-bit timestamp rollover marker ----
    doReset();
    en4 = 1'b1;
    applyStimulus(15);
    checkOutput("t5_no_marker_yet", count4, 0);
    applyStimulus(1);
    checkOutput("t5_marker_count", count4, 1);
    checkOutput("t5_marker_data", rdData4, 6'h0F);
    doReset();
    en4 = 1'b1;
    applyStimulus(15);
    spikeA4 = 1'b1;
    applyStimulus(1);
    checkOutput("t5_spike_wrap_data", rdData4, 6'h2F);
    checkOutput("t5_spike_wrap_count", count4, 1);
    applyStimulus(1);
    checkOutput("t5_no_extra_marker", count4, 1);
    spikeA4 = 1'b0;

    // ---- 6: disabled logging, then asynchronous reset mid-operation ----
    doReset();
    en = 1'b1;
    applyStimulus(3);
    en = 1'b0;
    spikeA = 1'b1;
    applyStimulus(1);
    spikeA = 1'b0;
    applyStimulus(9);
    checkOutput("t6_disabled_count", count, 0);
    en = 1'b1;
    spikeA = 1'b1;
    applyStimulus(1);
    checkOutput("t6_ts_held", rdData, 16'h8003);
    spikeA = 1'b0;
    applyStimulus(1);
    spikeB = 1'b1;
    applyStimulus(1);
    spikeB = 1'b0;
    applyStimulus(1);
    spikeA = 1'b1;
    applyStimulus(1);
    spikeA = 1'b0;
    checkOutput("t6_count_three", count, 3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", rdValid, 0);
    checkOutput("t6_async_count", count, 0);
    checkOutput("t6_async_ovf", overflowFlag, 0);
    checkOutput("t6_async_data", rdData, 0);
    #2;
    reset_n = 1'b1;
    applyStimulus(1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
